// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the FIFO write-side controller
package fifo_pkg;

    localparam int FIFO_DEPTH      = 256;
    localparam int FIFO_ADDR_WIDTH = 8;
    localparam int D_WIDTH         = 9;

    typedef enum logic [2:0] {
        ST_LOAD0 = 3'd0,
        ST_LOAD1 = 3'd1,
        ST_LOAD2 = 3'd2,
        ST_LOAD3 = 3'd3,
        ST_RUN   = 3'd4,
        ST_GAP1  = 3'd5,
        ST_GAP2  = 3'd6
    } wr_state_e;

endpackage

// File: rtl/fifo_offset_loader.sv
// rtl/fifo_offset_loader.sv - four-word WEN2 offset load sequencer
//
// Ports:
//   clk, rst_n  write clock, asynchronous active-low reset
//   start       restart the sequence (first word is issued the following cycle)
//   load_en     a load word is being issued this cycle
//   load_data   the load word: empty offset lo/hi, then full offset lo/hi
//   done        last of the four words is being issued this cycle
module fifo_offset_loader
    import fifo_pkg::*;
#(
    parameter logic [8:0] EMPTY_OFFSET = 9'd10,
    parameter logic [8:0] FULL_OFFSET  = 9'd10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               load_en,
    output logic [D_WIDTH-1:0] load_data,
    output logic               done
);

    logic [1:0] step_q, step_d;
    logic       busy_q, busy_d;

    always_comb begin
        step_d = step_q;
        busy_d = busy_q;
        if (start) begin
            step_d = 2'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
                busy_d = 1'b0;
            end
        end
    end

    // Out of reset the sequence is already running, since the
    // FIFO's own offset-load pointer restarts at the same moment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 2'd0;
            busy_q <= 1'b1;
        end else begin
            step_q <= step_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        load_data = '0;
        case (step_q)
            2'd0: load_data = {1'b0, EMPTY_OFFSET[7:0]};
            2'd1: load_data = {8'b0, EMPTY_OFFSET[8]};
            2'd2: load_data = {1'b0, FULL_OFFSET[7:0]};
            2'd3: load_data = {8'b0, FULL_OFFSET[8]};
            default: load_data = '0;
        endcase
    end

    assign load_en = busy_q;
    assign done    = busy_q && (step_q == 2'd3);

endmodule

// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - FIFO write-port controller: offset load, throttled streaming, word count
//
// Ports:
//   WCLK, RS_N         write clock, asynchronous active-low reset
//   PROG               single-cycle request to re-run the offset load
//   IN_DATA/IN_VALID/IN_READY  producer stream
//   FF, PAF            FIFO full / almost-full flags (registered, WCLK domain)
//   D, WEN1, WEN2      registered FIFO write port (enables active-low)
//   PROG_DONE          offsets loaded, block streaming
//   WR_COUNT           words written since reset, wrapping
// Optional macro FIFO_WR_PARITY_EN: D[8] of data writes carries even parity of IN_DATA[7:0].
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int         DEPTH        = 256,
    parameter logic [8:0] EMPTY_OFFSET = 9'd10,
    parameter logic [8:0] FULL_OFFSET  = 9'd10,
    parameter int         CNT_WIDTH    = 16
) (
    input  logic                 WCLK,
    input  logic                 RS_N,
    input  logic                 PROG,
    input  logic [8:0]           IN_DATA,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic                 FF,
    input  logic                 PAF,
    output logic [8:0]           D,
    output logic                 WEN1,
    output logic                 WEN2,
    output logic                 PROG_DONE,
    output logic [CNT_WIDTH-1:0] WR_COUNT
);

    if (DEPTH != FIFO_DEPTH || int'(FULL_OFFSET) < 3 || int'(FULL_OFFSET) > DEPTH - 1) begin : g_bad_cfg
        $error("fifo_write_ctrl: DEPTH must match the FIFO and FULL_OFFSET must be 3..DEPTH-1");
    end

    wr_state_e            state_q, state_d;
    logic [D_WIDTH-1:0]   d_q, d_d;
    logic                 wen1_q, wen1_d;
    logic                 wen2_q, wen2_d;
    logic                 done_q, done_d;
    logic                 pend_q, pend_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 load_start;
    logic                 load_en;
    logic                 load_done;
    logic [D_WIDTH-1:0]   load_data;
    logic [D_WIDTH-1:0]   wr_word;
    logic                 run_side;
    logic                 prog_pending;
    logic                 accept;

    fifo_offset_loader #(
        .EMPTY_OFFSET (EMPTY_OFFSET),
        .FULL_OFFSET  (FULL_OFFSET)
    ) u_loader (
        .clk       (WCLK),
        .rst_n     (RS_N),
        .start     (load_start),
        .load_en   (load_en),
        .load_data (load_data),
        .done      (load_done)
    );

`ifdef FIFO_WR_PARITY_EN
    assign wr_word = {^IN_DATA[7:0], IN_DATA[7:0]};
`else
    assign wr_word = IN_DATA;
`endif

    assign run_side = (state_q == ST_RUN) || (state_q == ST_GAP1) || (state_q == ST_GAP2);

    // A PROG arriving in the current RUN cycle already blocks the handshake,
    // so a simultaneous word is never accepted.
    assign prog_pending = pend_q || (PROG && run_side);
    assign IN_READY     = (state_q == ST_RUN) && !FF && !prog_pending;
    assign accept       = IN_VALID && IN_READY;

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        wen1_d     = 1'b1;
        wen2_d     = 1'b1;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        load_start = 1'b0;
        done_d     = run_side;

        if (load_en) begin
            wen2_d = 1'b0;
            d_d    = load_data;
        end

        case (state_q)
            ST_LOAD0: state_d = ST_LOAD1;
            ST_LOAD1: state_d = ST_LOAD2;
            ST_LOAD2: state_d = ST_LOAD3;
            ST_LOAD3: begin
                if (load_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (prog_pending) begin
                    state_d    = ST_LOAD0;
                    pend_d     = 1'b0;
                    load_start = 1'b1;
                end else if (accept) begin
                    d_d    = wr_word;
                    wen1_d = 1'b0;
                    cnt_d  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    // Near full, leave two idle cycles so FF is current
                    // before the next word can be accepted.
                    if (PAF) begin
                        state_d = ST_GAP1;
                    end
                end
            end
            ST_GAP1: begin
                state_d = ST_GAP2;
                pend_d  = prog_pending;
            end
            ST_GAP2: begin
                state_d = ST_RUN;
                pend_d  = prog_pending;
            end
            default: state_d = ST_LOAD0;
        endcase
    end

    always_ff @(posedge WCLK or negedge RS_N) begin
        if (!RS_N) begin
            state_q <= ST_LOAD0;
            d_q     <= '0;
            wen1_q  <= 1'b1;
            wen2_q  <= 1'b1;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            wen1_q  <= wen1_d;
            wen2_q  <= wen2_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign D         = d_q;
    assign WEN1      = wen1_q;
    assign WEN2      = wen2_q;
    assign PROG_DONE = done_q;
    assign WR_COUNT  = cnt_q;

endmodule
